instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch initiator for the processor datapath.
- On request from the control unit, reads the instruction word at the program counter from program memory using a req/ack handshake.
- Latches the word into the data register, pulses LDIR so the instruction register captures it, and advances the PC.
- Supports PC load (jump) and a memory-wait timeout.

Parameters:
ADDR_LEN, 8, width of program counter and memory address
DATA_LEN, 16, width of memory word and data register
TIMEOUT, 15, max cycles mem_rd may wait for mem_ack; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  control unit requests one instruction fetch (level, sampled in IDLE)
jump  input  1  load PC from jump_addr (sampled in IDLE)
jump_addr  input  ADDR_LEN  new PC value
mem_addr  output  ADDR_LEN  program memory address (registered)
mem_rd  output  1  memory read request (registered)
mem_ack  input  1  memory read data valid
mem_data  input  DATA_LEN  memory read data
DR_out  output  DATA_LEN  data register contents, feeds instruction register DR_in
LDIR  output  1  one-cycle load strobe to instruction register
pc_out  output  ADDR_LEN  current program counter
busy  output  1  high whenever state != IDLE
fetch_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc_out, mem_addr, DR_out, wait_cnt = 0; mem_rd, LDIR, fetch_err = 0. Reset mid-fetch aborts immediately: no LDIR, PC unchanged from 0.
- States: IDLE, READ, LOAD.
- IDLE:
  - jump=1 → pc<=jump_addr, fetch_err<=0, stay IDLE. Jump has priority over fetch_en in the same cycle; no fetch starts that cycle.
  - else fetch_en=1 → mem_addr<=pc, mem_rd<=1, wait_cnt<=0, fetch_err<=0, go READ.
- READ (mem_rd=1, mem_addr stable):
  - mem_ack=1 at edge → DR_out<=mem_data, mem_rd<=0, pc<=pc+1 (mod 2^ADDR_LEN, ADDR_LEN-bit wrap; 0xFF→0x00 at default), LDIR<=1, go LOAD.
  - mem_ack=0 and TIMEOUT!=0 and wait_cnt==TIMEOUT-1 → mem_rd<=0, fetch_err<=1, pc unchanged, DR_out unchanged, go IDLE.
  - otherwise wait_cnt<=wait_cnt+1, stay READ.
  - wait_cnt is wide enough to hold TIMEOUT.
- LOAD: LDIR=1 for exactly this one cycle; next edge LDIR<=0, go IDLE.
- Ignored inputs:
  - jump and fetch_en are ignored in READ and LOAD; no queuing.
  - mem_ack outside READ is ignored.
- Latency: fetch_en sampled at edge E0 → mem_rd high after E0.
  - ack at E1 → DR_out valid and LDIR high after E1 (one cycle); pc_out incremented after E1.
  - IDLE after E2; next fetch_en accepted at E3 earliest.
  - Minimum fetch period: 3 cycles.
- DR_out holds its value until the next successful fetch.
- Instruction register samples DR_out while LDIR=1.
- fetch_err stays high until the next accepted fetch or jump.

Test Plan:
- Reset: assert rst_n=0 mid-READ with mem_rd=1 → all outputs 0 asynchronously, no LDIR pulse; after release, state IDLE, pc_out=0.
- Single fetch, zero-wait: pc=0, fetch_en one cycle, mem_ack=1 with mem_data=16'h0025 in first READ cycle → mem_addr=0 while mem_rd=1, DR_out=16'h0025, LDIR high exactly 1 cycle, pc_out=1, busy low after 3 cycles.
- Delayed ack: mem_ack asserted 4 cycles after mem_rd → mem_rd held 5 cycles with mem_addr constant, single LDIR pulse, pc incremented once, fetch_err=0.
- Jump priority and wrap: jump=1 and fetch_en=1 together with jump_addr=8'hFF → pc_out=8'hFF, no mem_rd. Then fetch with data 16'h0003 → mem_addr=8'hFF, DR_out=16'h0003, pc_out=8'h00.
- Timeout: TIMEOUT=15, fetch_en with mem_ack held 0 → mem_rd high exactly 15 cycles then drops, fetch_err=1, LDIR never pulses, pc_out unchanged. Next fetch with ack → fetch_err clears to 0.
- Ignored inputs: pulse jump and fetch_en during READ and LOAD → pc_out only increments by 1 per completed fetch, no second request issued, stray mem_ack in IDLE causes no LDIR.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch initiator: reads the word at the PC over a req/ack
// handshake, latches it into DR, strobes LDIR for one cycle and advances the PC.
module instr_fetch_ctrl #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                jump,
  input  logic [ADDR_LEN-1:0] jump_addr,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_rd,
  input  logic                mem_ack,
  input  logic [DATA_LEN-1:0] mem_data,
  output logic [DATA_LEN-1:0] DR_out,
  output logic                LDIR,
  output logic [ADDR_LEN-1:0] pc_out,
  output logic                busy,
  output logic                fetch_err,
  output logic [1:0]          dbg_state
);

  // Memory handshake: mem_rd is raised with a stable mem_addr and held until
  // the first edge that sees mem_ack=1 (the read completes on that edge) or
  // until the wait budget runs out. mem_ack is ignored while mem_rd is low.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WCW'(TIMEOUT - 1);

  logic [1:0]          state_q,    state_d;
  logic [ADDR_LEN-1:0] pc_q,       pc_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic                mem_rd_q,   mem_rd_d;
  logic [DATA_LEN-1:0] dr_q,       dr_d;
  logic                ldir_q,     ldir_d;
  logic                err_q,      err_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    dr_d       = dr_q;
    ldir_d     = ldir_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // A jump wins over a fetch request in the same cycle.
        if (jump) begin
          pc_d  = jump_addr;
          err_d = 1'b0;
        end else if (fetch_en) begin
          mem_addr_d = pc_q;
          mem_rd_d   = 1'b1;
          wait_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          dr_d     = mem_data;
          mem_rd_d = 1'b0;
          pc_d     = pc_q + ADDR_LEN'(1);
          ldir_d   = 1'b1;
          state_d  = ST_LOAD;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_LOAD: begin
        ldir_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        mem_rd_d = 1'b0;
        ldir_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      dr_q       <= '0;
      ldir_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      dr_q       <= dr_d;
      ldir_q     <= ldir_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign DR_out    = dr_q;
  assign LDIR      = ldir_q;
  assign pc_out    = pc_q;
  assign busy      = (state_q != ST_IDLE);
  assign fetch_err = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a driver issues fetches/jumps against a program
// memory array and a reference PC; a monitor pops expected reads and loads.
module tb_instr_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          jump = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] DR_out;
  logic          LDIR;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic          fetch_err;
  logic [1:0]    dbg_state;

  instr_fetch_ctrl #(.ADDR_LEN(AW), .DATA_LEN(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .jump(jump),
    .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_data(mem_data), .DR_out(DR_out), .LDIR(LDIR),
    .pc_out(pc_out), .busy(busy), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state and scoreboard queues
  logic [DW-1:0]    mem [256];
  logic [AW-1:0]    model_pc = '0;
  logic             model_err = 1'b0;
  logic [AW-1:0]    exp_rd_q[$];
  logic [7:0]       exp_len_q[$];
  logic [DW+AW-1:0] exp_ld_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic          prev_rd = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  int            run = 0;
  always @(posedge clk) begin
    logic [DW+AW-1:0] e;
    #1;
    if (!rst_n) begin
      prev_rd = 1'b0;
      run = 0;
    end else begin
      if (LDIR === 1'b1) begin
        if (exp_ld_q.size() == 0) chk("ldir_unexpected", 32'(LDIR), 32'd0);
        else begin
          e = exp_ld_q.pop_front();
          chk("dr_out", 32'(DR_out), 32'(e[DW+AW-1:AW]));
          chk("pc_after_load", 32'(pc_out), 32'(e[AW-1:0]));
        end
      end
      if (mem_rd && !prev_rd) begin
        run = 1;
        cur_addr = mem_addr;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'(mem_rd), 32'd0);
        else chk("mem_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
      end else if (mem_rd && prev_rd) begin
        run++;
        chk("mem_addr_stable", 32'(mem_addr), 32'(cur_addr));
      end else if (!mem_rd && prev_rd) begin
        if (exp_len_q.size() == 0) chk("rd_len_unexpected", 32'(run), 32'd0);
        else chk("mem_rd_cycles", 32'(run), 32'(exp_len_q.pop_front()));
      end
      prev_rd = mem_rd;
    end
  end

  task automatic do_fetch(input int d, input bit stray);
    logic [DW-1:0] w;
    @(negedge clk);
    fetch_en = 1'b1; jump = 1'b0;
    exp_rd_q.push_back(model_pc);
    exp_len_q.push_back(8'(d + 1));
    @(negedge clk);
    fetch_en = 1'b0;
    for (int i = 0; i < d; i++) begin
      if (stray) begin
        fetch_en = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        jump_addr = 8'($urandom);
      end
      @(negedge clk);
    end
    w = mem[model_pc];
    mem_ack = 1'b1; mem_data = w;
    model_pc = model_pc + 8'd1;
    exp_ld_q.push_back({w, model_pc});
    @(negedge clk);
    if (stray) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_data = 16'($urandom);
      fetch_en = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      jump_addr = 8'($urandom);
    end else mem_ack = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0; fetch_en = 1'b0; jump = 1'b0;
    model_err = 1'b0;
    chk("busy_after_fetch", 32'(busy), 32'd0);
    chk("err_after_fetch", 32'(fetch_err), 32'd0);
    chk("pc_after_fetch", 32'(pc_out), 32'(model_pc));
  endtask

  task automatic do_timeout();
    int k;
    @(negedge clk);
    fetch_en = 1'b1; jump = 1'b0; mem_ack = 1'b0;
    exp_rd_q.push_back(model_pc);
    exp_len_q.push_back(8'(TO));
    @(negedge clk);
    fetch_en = 1'b0;
    k = 0;
    while (busy && k < TO + 5) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_wait_busy", 32'(busy), 32'd0);
    model_err = 1'b1;
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("timeout_pc", 32'(pc_out), 32'(model_pc));
    chk("timeout_rd", 32'(mem_rd), 32'd0);
  endtask

  task automatic do_jump(input logic [AW-1:0] a, input bit fe);
    @(negedge clk);
    jump = 1'b1; jump_addr = a; fetch_en = fe;
    @(negedge clk);
    jump = 1'b0; fetch_en = 1'b0;
    model_pc = a; model_err = 1'b0;
    chk("jump_pc", 32'(pc_out), 32'(a));
    chk("jump_no_rd", 32'(mem_rd), 32'd0);
    chk("jump_not_busy", 32'(busy), 32'd0);
    chk("jump_err_clear", 32'(fetch_err), 32'd0);
  endtask

  task automatic do_idle_ack();
    @(negedge clk);
    mem_ack = 1'b1; mem_data = 16'($urandom);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_pc", 32'(pc_out), 32'(model_pc));
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_err", 32'(fetch_err), 32'(model_err));
  endtask

  task automatic do_reset_mid_read();
    @(negedge clk);
    fetch_en = 1'b1; jump = 1'b0; mem_ack = 1'b0;
    exp_rd_q.push_back(model_pc);
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    chk("pre_reset_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_ldir", 32'(LDIR), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_dr", 32'(DR_out), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = '0; model_err = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    chk("post_rst_pc", 32'(pc_out), 32'd0);
  endtask

  initial begin
    int op;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0025;
    mem[8'hFF] = 16'h0003;
    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(pc_out), 32'd0);
    chk("reset_rd", 32'(mem_rd), 32'd0);
    chk("reset_ldir", 32'(LDIR), 32'd0);
    chk("reset_dr", 32'(DR_out), 32'd0);
    chk("reset_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);

    do_fetch(0, 1'b0);
    chk("zero_wait_dr", 32'(DR_out), 32'h0025);
    chk("zero_wait_pc", 32'(pc_out), 32'd1);
    do_fetch(4, 1'b0);
    do_jump(8'hFF, 1'b1);
    do_fetch(0, 1'b0);
    chk("wrap_dr", 32'(DR_out), 32'h0003);
    chk("wrap_pc", 32'(pc_out), 32'd0);
    do_timeout();
    do_idle_ack();
    do_fetch(2, 1'b0);
    do_fetch(3, 1'b1);
    do_idle_ack();

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 6)       do_fetch($urandom_range(0, 6), 1'($urandom_range(0, 1)));
      else if (op < 8)  do_jump(8'($urandom), 1'($urandom_range(0, 1)));
      else if (op == 8) do_timeout();
      else              do_idle_ack();
    end

    do_reset_mid_read();
    do_fetch(1, 1'b0);
    repeat (2) @(negedge clk);
    chk("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    chk("len_q_drained", 32'(exp_len_q.size()), 32'd0);
    chk("ld_q_drained", 32'(exp_ld_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
